// File: rtl/mtc_ppa_gnt_serializer.sv
// mTC-PPA grant serializer: edge-detects AMOUNT_M nested thermometer masks into one-hot
// grants, buffers one beat of them and emits them one per handshake in priority order.

module mtc_ppa_gnt_layer_dec #(
  parameter int WIDTH_N = 10,
  parameter int IDX_W   = 4
) (
  input  logic [WIDTH_N-1:0] t,
  output logic [WIDTH_N-1:0] oh,
  output logic [IDX_W-1:0]   idx,
  output logic               any,
  output logic               bad_form
);
  logic prev;

  // Rising edge of the thermometer from the LSB marks the granted requester.
  always_comb begin
    oh   = '0;
    idx  = '0;
    prev = 1'b0;
    for (int j = 0; j < WIDTH_N; j++) begin
      oh[j] = t[j] & ~prev;
      prev  = t[j];
    end
    for (int j = 0; j < WIDTH_N; j++)
      if (oh[j]) idx = idx | IDX_W'(j);
  end

  // A set bit followed by a clear bit above it means the layer is not a thermometer.
  always_comb begin
    bad_form = 1'b0;
    for (int j = 0; j < WIDTH_N-1; j++)
      if (t[j] & ~t[j+1]) bad_form = 1'b1;
  end

  assign any = |oh;
endmodule

module mtc_ppa_gnt_serializer #(
  parameter int WIDTH_N  = 10,
  parameter int AMOUNT_M = 2,
  localparam int IDX_W   = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [AMOUNT_M-1:0][WIDTH_N-1:0]  mask_i,
  input  logic                              mask_vld_i,
  output logic                              mask_rdy_o,
  output logic [WIDTH_N-1:0]                gnt_o,
  output logic [IDX_W-1:0]                  gnt_idx_o,
  output logic                              gnt_last_o,
  output logic                              gnt_vld_o,
  input  logic                              gnt_rdy_i,
  output logic                              err_o
);
  localparam int CW = $clog2(AMOUNT_M+1);

  typedef enum logic {IDLE, SERVE} state_t;

  typedef struct packed {
    logic [WIDTH_N-1:0] oh;
    logic [IDX_W-1:0]   idx;
  } gnt_t;

  state_t state_q, state_d;

  logic [AMOUNT_M-1:0][WIDTH_N-1:0] dec_oh, slot_oh;
  logic [AMOUNT_M-1:0][IDX_W-1:0]   dec_idx, slot_idx;
  logic [AMOUNT_M-1:0]              dec_any, dec_bad;
  logic [CW-1:0]                    cnt_in, cnt_q, ptr_q;
  logic                             nest_bad, beat_bad;
  logic                             serve, last, gnt_done, accept;
  gnt_t                             cur;

  // Lane g decodes grant k=g+1, which lives in layer AMOUNT_M-k.
  for (genvar g = 0; g < AMOUNT_M; g++) begin : g_dec
    mtc_ppa_gnt_layer_dec #(.WIDTH_N(WIDTH_N), .IDX_W(IDX_W)) u_dec (
      .t        (mask_i[AMOUNT_M-1-g]),
      .oh       (dec_oh[g]),
      .idx      (dec_idx[g]),
      .any      (dec_any[g]),
      .bad_form (dec_bad[g])
    );
  end

  always_comb begin
    cnt_in = '0;
    for (int k = 0; k < AMOUNT_M; k++)
      cnt_in = cnt_in + CW'(dec_any[k]);
  end

  // Lower layers need more requests, so each must be a subset of the layer above it.
  always_comb begin
    nest_bad = 1'b0;
    for (int i = 0; i < AMOUNT_M-1; i++)
      if (|(mask_i[i] & ~mask_i[i+1])) nest_bad = 1'b1;
  end

  assign beat_bad = (|dec_bad) | nest_bad;

  always_comb begin
    cur = '0;
    for (int k = 0; k < AMOUNT_M; k++)
      if (ptr_q == CW'(k+1)) begin
        cur.oh  = slot_oh[k];
        cur.idx = slot_idx[k];
      end
  end

  assign serve      = (state_q == SERVE);
  assign last       = serve & (ptr_q == cnt_q);
  assign gnt_done   = serve & gnt_rdy_i & last;
  assign mask_rdy_o = ~serve | gnt_done;
  assign accept     = mask_vld_i & mask_rdy_o;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)        state_d = (cnt_in != '0) ? SERVE : IDLE;
    else if (gnt_done) state_d = IDLE;
  end

  always_comb begin
    gnt_vld_o  = serve;
    gnt_o      = serve ? cur.oh  : '0;
    gnt_idx_o  = serve ? cur.idx : '0;
    gnt_last_o = last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_oh  <= '0;
      slot_idx <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      err_o    <= 1'b0;
    end else begin
      if (accept) begin
        slot_oh  <= dec_oh;
        slot_idx <= dec_idx;
        cnt_q    <= cnt_in;
        ptr_q    <= (cnt_in != '0) ? CW'(1) : '0;
        if (beat_bad) err_o <= 1'b1;
      end else if (gnt_done) begin
        ptr_q <= '0;
      end else if (serve & gnt_rdy_i) begin
        ptr_q <= ptr_q + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mtc_ppa_gnt_serializer.sv
// Directed bench for mtc_ppa_gnt_serializer at WIDTH_N=10, AMOUNT_M=2.
module tb_mtc_ppa_gnt_serializer;
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0][9:0]  mask;
  logic             mask_vld, mask_rdy;
  logic [9:0]       gnt;
  logic [3:0]       gnt_idx;
  logic             gnt_last, gnt_vld, gnt_rdy, err;
  int               total = 0;
  int               bad   = 0;

  always #5 clk = ~clk;

  mtc_ppa_gnt_serializer #(.WIDTH_N(10), .AMOUNT_M(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .mask_i     (mask),
    .mask_vld_i (mask_vld),
    .mask_rdy_o (mask_rdy),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_last_o (gnt_last),
    .gnt_vld_o  (gnt_vld),
    .gnt_rdy_i  (gnt_rdy),
    .err_o      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic v, input logic [9:0] g,
                         input logic [3:0] i, input logic l);
    chk({tag, ".vld"},  32'(gnt_vld),  32'(v));
    chk({tag, ".gnt"},  32'(gnt),      32'(g));
    chk({tag, ".idx"},  32'(gnt_idx),  32'(i));
    chk({tag, ".last"}, 32'(gnt_last), 32'(l));
  endtask

  // Advance to the next falling edge; inputs change here, checks follow #1 later.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; mask = '0; mask_vld = 1'b0; gnt_rdy = 1'b0;
    repeat (2) @(posedge clk);
    cyc(); reset = 1'b0; #1;
    chk_gnt("rst", 1'b0, 10'h000, 4'd0, 1'b0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.mrdy", 32'(mask_rdy), 32'd1);

    // 1: req=0x014 -> grants 0x004/idx2 then 0x010/idx4
    cyc(); mask[0] = 10'h3F0; mask[1] = 10'h3FC; mask_vld = 1'b1; gnt_rdy = 1'b1; #1;
    chk("t1.mrdy0", 32'(mask_rdy), 32'd1);
    chk("t1.vld0", 32'(gnt_vld), 32'd0);
    cyc(); mask_vld = 1'b0; #1;
    chk_gnt("t1.g1", 1'b1, 10'h004, 4'd2, 1'b0);
    chk("t1.mrdy1", 32'(mask_rdy), 32'd0);
    cyc(); #1;
    chk_gnt("t1.g2", 1'b1, 10'h010, 4'd4, 1'b1);
    chk("t1.mrdy2", 32'(mask_rdy), 32'd1);
    cyc(); #1;
    chk_gnt("t1.idle", 1'b0, 10'h000, 4'd0, 1'b0);
    chk("t1.err", 32'(err), 32'd0);

    // 2: empty request consumed silently
    cyc(); mask = '0; mask_vld = 1'b1; #1;
    chk("t2.mrdy0", 32'(mask_rdy), 32'd1);
    cyc(); mask_vld = 1'b0; #1;
    chk("t2.vld1", 32'(gnt_vld), 32'd0);
    chk("t2.mrdy1", 32'(mask_rdy), 32'd1);
    cyc(); #1;
    chk("t2.vld2", 32'(gnt_vld), 32'd0);

    // 3: single request at bit 7
    cyc(); mask[0] = 10'h000; mask[1] = 10'h380; mask_vld = 1'b1; #1;
    cyc(); mask_vld = 1'b0; #1;
    chk_gnt("t3.g1", 1'b1, 10'h080, 4'd7, 1'b1);
    cyc(); #1;
    chk("t3.idle", 32'(gnt_vld), 32'd0);

    // 4: back-pressure holds the first grant
    cyc(); mask[0] = 10'h3F0; mask[1] = 10'h3FC; mask_vld = 1'b1; gnt_rdy = 1'b0; #1;
    cyc(); mask_vld = 1'b0; #1;
    for (int n = 0; n < 3; n++) begin
      chk_gnt("t4.hold", 1'b1, 10'h004, 4'd2, 1'b0);
      chk("t4.mrdy", 32'(mask_rdy), 32'd0);
      cyc(); #1;
    end
    gnt_rdy = 1'b1; #1;
    chk_gnt("t4.rel", 1'b1, 10'h004, 4'd2, 1'b0);
    cyc(); #1;
    chk_gnt("t4.g2", 1'b1, 10'h010, 4'd4, 1'b1);
    cyc(); #1;
    chk("t4.idle", 32'(gnt_vld), 32'd0);

    // 5: back-to-back beats; second is req bits 1 and 9
    cyc(); mask[0] = 10'h3F0; mask[1] = 10'h3FC; mask_vld = 1'b1; #1;
    cyc(); mask[0] = 10'h200; mask[1] = 10'h3FE; #1;
    chk_gnt("t5.a1", 1'b1, 10'h004, 4'd2, 1'b0);
    chk("t5.mrdy_a1", 32'(mask_rdy), 32'd0);
    cyc(); #1;
    chk_gnt("t5.a2", 1'b1, 10'h010, 4'd4, 1'b1);
    chk("t5.mrdy_a2", 32'(mask_rdy), 32'd1);
    cyc(); mask_vld = 1'b0; #1;
    chk_gnt("t5.b1", 1'b1, 10'h002, 4'd1, 1'b0);
    cyc(); #1;
    chk_gnt("t5.b2", 1'b1, 10'h200, 4'd9, 1'b1);
    chk("t5.mrdy_b2", 32'(mask_rdy), 32'd1);
    cyc(); #1;
    chk("t5.idle", 32'(gnt_vld), 32'd0);
    chk("t5.err", 32'(err), 32'd0);

    // 6: non-nested layers set err; reset mid-SERVE clears everything
    cyc(); mask[0] = 10'h3FC; mask[1] = 10'h3F0; mask_vld = 1'b1; gnt_rdy = 1'b0; #1;
    chk("t6.err0", 32'(err), 32'd0);
    cyc(); mask_vld = 1'b0; #1;
    chk("t6.err1", 32'(err), 32'd1);
    chk_gnt("t6.g1", 1'b1, 10'h010, 4'd4, 1'b0);
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    chk_gnt("t6.rst", 1'b0, 10'h000, 4'd0, 1'b0);
    chk("t6.rst_err", 32'(err), 32'd0);
    chk("t6.rst_mrdy", 32'(mask_rdy), 32'd1);

    // 7: layer that is not a thermometer (bit0 set, bit1 clear) sets err
    cyc(); mask[0] = 10'h000; mask[1] = 10'h3FD; mask_vld = 1'b1; gnt_rdy = 1'b1; #1;
    cyc(); mask_vld = 1'b0; #1;
    chk("t7.err", 32'(err), 32'd1);
    chk_gnt("t7.g1", 1'b1, 10'h005, 4'd2, 1'b1);
    cyc(); #1;
    chk("t7.idle", 32'(gnt_vld), 32'd0);
    chk("t7.sticky", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
